median_window_feeder: RTL and testbench

//  Upstream stage of the 3x3 median filter. Takes a raster pixel stream, keeps two line buffers
//  and a 3x3 window, and for every fully-interior window emits the 9 pixels as one burst on DO/DSO.
//  It then stalls until the median stage pulses MED_DONE. Output image is (IMG_W-2)x(IMG_H-2); no border padding.

---
 rtl/median_window_feeder_if.sv | 24 ++
 rtl/median_window_feeder.sv | 117 +++++++++++
 tb/tb_median_window_feeder.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/median_window_feeder_if.sv
// Pixel-in / window-out bundle between the raster source,
// the window feeder and the median stage.
interface median_window_feeder_if #(
   parameter int W = 8
);
   logic [W-1:0] PIX_IN;
   logic         PIX_VAL;
   logic         SOF;
   logic         PIX_RDY;
   logic [W-1:0] DO;
   logic         DSO;
   logic         MED_DONE;
   logic         EOF;

   modport master (
      output PIX_IN, PIX_VAL, SOF, MED_DONE,
      input  PIX_RDY, DO, DSO, EOF
   );

   modport slave (
      input  PIX_IN, PIX_VAL, SOF, MED_DONE,
      output PIX_RDY, DO, DSO, EOF
   );
endinterface

// File: rtl/median_window_feeder.sv
// 3x3 window builder: two line buffers plus a shifting
// window, bursting 9 pixels per interior window.
module median_window_feeder #(
   parameter int W     = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input logic CLK,
   input logic nRST,
   median_window_feeder_if.slave bus
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   localparam logic [1:0] S_ACCEPT = 2'd0;
   localparam logic [1:0] S_BURST  = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [XW-1:0]       x_q, x_d;
   logic [YW-1:0]       y_q, y_d;
   logic [3:0]          k_q, k_d;
   logic [8:0][W-1:0]   win_q, win_d;
   logic                eof_q, eof_d;

   logic [W-1:0]        lb0 [IMG_W];
   logic [W-1:0]        lb1 [IMG_W];

   logic                pix_rdy;
   logic                accept;
   logic [XW-1:0]       cx;
   logic [YW-1:0]       cy;
   logic                last_x;
   logic                last_y;

   // Ready is masked by reset so it drops asynchronously.
   assign pix_rdy = (state_q == S_ACCEPT) && !nRST;
   assign accept  = bus.PIX_VAL && pix_rdy;
   assign cx      = bus.SOF ? '0 : x_q;
   assign cy      = bus.SOF ? '0 : y_q;
   assign last_x  = (cx == XW'(IMG_W - 1));
   assign last_y  = (cy == YW'(IMG_H - 1));

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      k_d     = k_q;
      win_d   = win_q;
      eof_d   = 1'b0;
      unique case (1'b1)
         (state_q == S_ACCEPT): begin
            if (accept) begin
               for (int r = 0; r < 3; r++) begin
                  win_d[r*3]   = win_q[r*3+1];
                  win_d[r*3+1] = win_q[r*3+2];
               end
               win_d[2] = lb1[cx];
               win_d[5] = lb0[cx];
               win_d[8] = bus.PIX_IN;
               if (last_x) begin
                  x_d   = '0;
                  y_d   = last_y ? '0 : cy + 1'b1;
                  eof_d = last_y;
               end else begin
                  x_d = cx + 1'b1;
                  y_d = cy;
               end
               if (cx >= XW'(2) && cy >= YW'(2)) begin
                  state_d = S_BURST;
                  k_d     = '0;
               end
            end
         end
         (state_q == S_BURST): begin
            k_d = k_q + 4'd1;
            if (k_q == 4'd8)
               state_d = S_WAIT;
         end
         (state_q == S_WAIT): begin
            if (bus.MED_DONE)
               state_d = S_ACCEPT;
         end
         default: state_d = S_ACCEPT;
      endcase
   end

   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         state_q <= S_ACCEPT;
         x_q     <= '0;
         y_q     <= '0;
         k_q     <= '0;
         win_q   <= '0;
         eof_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         k_q     <= k_d;
         win_q   <= win_d;
         eof_q   <= eof_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         lb1[cx] <= lb0[cx];
         lb0[cx] <= bus.PIX_IN;
      end
   end

   assign bus.PIX_RDY = pix_rdy;
   assign bus.DSO     = (state_q == S_BURST);
   assign bus.DO      = (state_q == S_BURST) ? win_q[k_q] : '0;
   assign bus.EOF     = eof_q;
endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder on a 4x4 frame with a
// coordinate-indexed image model and expected-burst table.
module tb_median_window_feeder;
   localparam int W  = 8;
   localparam int IW = 4;
   localparam int IH = 4;

   logic CLK;
   logic nRST;

   median_window_feeder_if #(.W(W)) bus ();

   median_window_feeder #(
      .W(W), .IMG_W(IW), .IMG_H(IH)
   ) dut (
      .CLK(CLK),
      .nRST(nRST),
      .bus(bus)
   );

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic [7:0] last_pix;
      logic [7:0] beats [9];
   } vec_t;

   vec_t tbl [4];

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] img [IH][IW];
   logic [7:0] exp_q [$];
   logic [7:0] captured [$];
   int  burst_left = 0;
   bit  waiting = 0;
   bit  eof_exp = 0;
   int  mx = 0, my = 0;
   int  eof_cnt = 0;
   int  cyc = 0;
   int  last_done = 0;
   bit  check23 = 0;
   int  beat_run = 0, last_run = 0;
   bit  auto_done = 1;
   bit  rnd_delay = 0;
   bit  prev_dso = 0;

   function automatic void chk(string name, logic [31:0] act,
                               logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t",
                  name, act, req, $time);
      end
   endfunction

   // Reference model: expected strobe, ready, EOF and beats.
   always @(negedge CLK) begin
      bit in_burst, in_wait;
      cyc++;
      if (nRST) begin
         burst_left = 0;
         waiting    = 0;
         eof_exp    = 0;
         mx = 0;
         my = 0;
         exp_q.delete();
         beat_run = 0;
      end else begin
         in_burst = (burst_left > 0);
         in_wait  = waiting;
         if (bus.DSO) begin
            captured.push_back(bus.DO);
            beat_run++;
         end else if (beat_run > 0) begin
            last_run = beat_run;
            beat_run = 0;
         end
         chk("dso", bus.DSO, in_burst);
         if (in_burst) begin
            chk("do", bus.DO, exp_q[0]);
            void'(exp_q.pop_front());
            burst_left--;
         end
         chk("pix_rdy", bus.PIX_RDY, !(in_burst || in_wait));
         chk("eof", bus.EOF, eof_exp);
         if (bus.EOF) eof_cnt++;
         eof_exp = 0;
         if (in_wait && bus.MED_DONE) begin
            waiting   = 0;
            last_done = cyc;
         end
         if (in_burst && burst_left == 0) waiting = 1;
         if (!in_burst && !in_wait && bus.PIX_VAL) begin
            if (bus.SOF) begin
               mx = 0;
               my = 0;
            end
            img[my][mx] = bus.PIX_IN;
            if (check23 && bus.PIX_IN == 8'h23)
               chk("px23_after_done", cyc - last_done, 1);
            if (mx >= 2 && my >= 2) begin
               for (int r = 0; r < 3; r++)
                  for (int c = 0; c < 3; c++)
                     exp_q.push_back(img[my-2+r][mx-2+c]);
               burst_left = 9;
            end
            if (mx == IW - 1) begin
               mx = 0;
               if (my == IH - 1) begin
                  my = 0;
                  eof_exp = 1;
               end else my++;
            end else mx++;
         end
      end
   end

   // Median-stage stand-in: pulses MED_DONE after each burst.
   always begin
      int d;
      @(negedge CLK);
      if (auto_done && prev_dso && !bus.DSO && !nRST) begin
         d = rnd_delay ? int'($urandom_range(1, 5)) : 3;
         repeat (d) @(posedge CLK);
         #1 bus.MED_DONE = 1;
         @(posedge CLK);
         #1 bus.MED_DONE = 0;
         prev_dso = 0;
      end else prev_dso = bus.DSO;
   end

   task automatic send(input logic [7:0] p, input bit s);
      bit ok;
      ok = 0;
      bus.PIX_IN  = p;
      bus.SOF     = s;
      bus.PIX_VAL = 1;
      for (int n = 0; n < 200; n++) begin
         @(negedge CLK);
         if (bus.PIX_RDY) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 0, 1);
      @(posedge CLK);
      #1;
      bus.PIX_VAL = 0;
      bus.SOF     = 0;
   endtask

   task automatic send_frame(input logic [7:0] base);
      for (int y = 0; y < IH; y++)
         for (int x = 0; x < IW; x++)
            send(base + 8'(16*y + x), (x == 0 && y == 0));
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      repeat (3) @(negedge CLK);
      for (int n = 0; n < 100; n++) begin
         @(negedge CLK);
         if (bus.PIX_RDY && !bus.DSO) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", 0, 1);
   endtask

   task automatic cmp_burst(input string name, input int at,
                            input int b, input logic [7:0] ofs);
      for (int i = 0; i < 9; i++)
         if (at + i < captured.size())
            chk(name, captured[at+i], tbl[b].beats[i] + ofs);
   endtask

   initial begin
      bit ok;
      int n;

      tbl[0].last_pix = 8'h22;
      tbl[0].beats = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11,
                       8'h12, 8'h20, 8'h21, 8'h22};
      tbl[1].last_pix = 8'h23;
      tbl[1].beats = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12,
                       8'h13, 8'h21, 8'h22, 8'h23};
      tbl[2].last_pix = 8'h32;
      tbl[2].beats = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21,
                       8'h22, 8'h30, 8'h31, 8'h32};
      tbl[3].last_pix = 8'h33;
      tbl[3].beats = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22,
                       8'h23, 8'h31, 8'h32, 8'h33};

      nRST         = 1;
      bus.PIX_IN   = 0;
      bus.PIX_VAL  = 0;
      bus.SOF      = 0;
      bus.MED_DONE = 0;
      repeat (3) @(negedge CLK);
      chk("rst_rdy", bus.PIX_RDY, 0);
      chk("rst_dso", bus.DSO, 0);
      chk("rst_do", bus.DO, 0);
      chk("rst_eof", bus.EOF, 0);
      @(posedge CLK);
      #1 nRST = 0;

      // Frame streaming, burst contents, held pixel, EOF.
      captured.delete();
      eof_cnt = 0;
      check23 = 1;
      send_frame(8'h00);
      drain();
      check23 = 0;
      chk("frame_beats", captured.size(), 36);
      for (int b = 0; b < 4; b++) begin
         cmp_burst("frame_burst", b*9, b, 8'h00);
         if (b*9 + 8 < captured.size())
            chk("burst_end", captured[b*9+8], tbl[b].last_pix);
      end
      chk("eof_count", eof_cnt, 1);

      // Early MED_DONE ignored, then a long WAIT.
      auto_done = 0;
      fork
         send_frame(8'h00);
         begin
            ok = 0;
            for (n = 0; n < 300; n++) begin
               @(negedge CLK);
               if (bus.DSO) begin
                  ok = 1;
                  break;
               end
            end
            if (!ok) chk("b4_start_timeout", 0, 1);
            repeat (2) @(negedge CLK);
            @(posedge CLK);
            #1 bus.MED_DONE = 1;
            @(posedge CLK);
            #1 bus.MED_DONE = 0;
            ok = 0;
            for (n = 0; n < 20; n++) begin
               @(negedge CLK);
               if (!bus.DSO) begin
                  ok = 1;
                  break;
               end
            end
            if (!ok) chk("b4_end_timeout", 0, 1);
            chk("burst_len", last_run, 9);
            for (int i = 0; i < 50; i++) begin
               @(negedge CLK);
               chk("wait_rdy", bus.PIX_RDY, 0);
            end
            @(posedge CLK);
            #1 bus.MED_DONE = 1;
            @(posedge CLK);
            #1 bus.MED_DONE = 0;
            auto_done = 1;
         end
      join
      drain();

      // SOF on (3,2) restarts the frame.
      captured.delete();
      eof_cnt = 0;
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < IW; x++)
            if (!(y == 2 && x == 3))
               send(8'(16*y + x), (x == 0 && y == 0));
      send_frame(8'h40);
      drain();
      chk("sof_beats", captured.size(), 45);
      cmp_burst("sof_old", 0, 0, 8'h00);
      cmp_burst("sof_first", 9, 0, 8'h40);
      cmp_burst("sof_last", 36, 3, 8'h40);
      chk("sof_eof", eof_cnt, 1);

      // Reset in the middle of a burst.
      fork
         begin
            for (int y = 0; y < 3; y++)
               for (int x = 0; x < 3 + (y < 2 ? 1 : 0); x++)
                  send(8'(16*y + x), (x == 0 && y == 0));
         end
         begin
            n = 0;
            for (int i = 0; i < 300 && n < 5; i++) begin
               @(negedge CLK);
               if (bus.DSO) n++;
            end
            chk("b6_beats", n, 5);
            #2 nRST = 1;
            #1;
            chk("b6_dso", bus.DSO, 0);
            chk("b6_rdy", bus.PIX_RDY, 0);
         end
      join
      repeat (2) @(posedge CLK);
      #1 nRST = 0;
      captured.delete();
      eof_cnt = 0;
      send_frame(8'h00);
      drain();
      chk("post_rst_beats", captured.size(), 36);
      for (int b = 0; b < 4; b++)
         cmp_burst("post_rst_burst", b*9, b, 8'h00);
      chk("post_rst_eof", eof_cnt, 1);

      // Random pixels, gaps and MED_DONE latency.
      rnd_delay = 1;
      eof_cnt = 0;
      for (int f = 0; f < 3; f++)
         for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++) begin
               repeat ($urandom_range(0, 2)) @(posedge CLK);
               #1;
               send(8'($urandom), (x == 0 && y == 0));
            end
      drain();
      chk("rnd_eof", eof_cnt, 3);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
